// File: rtl/accum_7seg_pkg.sv
// Shared types, segment table and encoder for the
// AXI-Stream accumulator with seven-segment output.
package accum_7seg_pkg;

  typedef enum logic [1:0] {
    ACCUM,
    CONVERT,
    OUTPUT
  } state_t;

  // bit0 = a .. bit6 = g, active-high
  localparam logic [6:0] SEG_LUT [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  function automatic logic [6:0] seg_encode(
    input logic [3:0] bcd,
    input logic       act_low
  );
    logic [6:0] s;
    if (bcd > 4'd9) s = 7'h00;
    else            s = SEG_LUT[bcd];
    return act_low ? ~s : s;
  endfunction

endpackage

// File: rtl/axis_accum_7seg_bin2bcd.sv
// Sequential double-dabble: one input bit per cycle,
// IN_W cycles from start to done.
module bin2bcd_seq
  import accum_7seg_pkg::*;
#(
  parameter int IN_W     = 6,
  parameter int N_DIGITS = 2,
  localparam int BW      = 4 * N_DIGITS,
  localparam int CW      = $clog2(IN_W + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [IN_W-1:0] bin,
  output logic            busy,
  output logic            done,
  output logic [BW-1:0]   bcd
);

  logic            r_busy;
  logic [IN_W-1:0] r_bin;
  logic [BW-1:0]   r_bcd;
  logic [CW-1:0]   r_cnt;
  logic [BW-1:0]   w_adj;
  logic [BW-1:0]   w_nxt;

  always_comb begin
    w_adj = r_bcd;
    for (int d = 0; d < N_DIGITS; d++) begin
      if (r_bcd[4*d +: 4] >= 4'd5)
        w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
    end
    // carries out of the top digit are dropped
    w_nxt = {w_adj[BW-2:0], r_bin[IN_W-1]};
  end

  assign busy = r_busy;
  assign done = r_busy && (r_cnt == CW'(IN_W - 1));
  assign bcd  = w_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_bin  <= '0;
      r_bcd  <= '0;
      r_cnt  <= '0;
    end else if (start) begin
      r_busy <= 1'b1;
      r_bin  <= bin;
      r_bcd  <= '0;
      r_cnt  <= '0;
    end else if (r_busy) begin
      r_bcd  <= w_nxt;
      r_bin  <= r_bin << 1;
      r_cnt  <= r_cnt + CW'(1);
      if (done) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_accum_7seg.sv
// Frame accumulator: sums AXI-Stream beats, converts the
// sum to BCD and presents seven-segment codes.
module axis_accum_7seg
  import accum_7seg_pkg::*;
#(
  parameter int WIDTH       = 3,
  parameter int NO_OF_STEPS = 4,
  parameter int N_DIGITS    = 2,
  parameter bit SEG_ACT_LOW = 1'b0,
  localparam int CNT_W      = $clog2(NO_OF_STEPS + 1),
  localparam int SUM_W      = WIDTH + CNT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [WIDTH-1:0]         s_data,
  input  logic                     s_last,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [N_DIGITS-1:0][6:0] m_data,
  output logic [SUM_W-1:0]         m_sum,
  output logic [CNT_W-1:0]         m_count,
  output logic                     m_ovf
);

  localparam int MAX_DEC = 10 ** N_DIGITS - 1;

  state_t                    r_state;
  logic [SUM_W-1:0]          r_sum;
  logic [CNT_W-1:0]          r_cnt;
  logic                      r_s_ready;
  logic                      r_m_valid;
  logic [N_DIGITS-1:0][6:0]  r_m_data;
  logic [SUM_W-1:0]          r_m_sum;
  logic [CNT_W-1:0]          r_m_count;
  logic                      r_m_ovf;

  logic                      w_hs;
  logic [SUM_W-1:0]          w_sum_nxt;
  logic [CNT_W-1:0]          w_cnt_nxt;
  logic                      w_close;
  logic                      w_busy;
  logic                      w_done;
  logic [4*N_DIGITS-1:0]     w_bcd;
  logic                      w_ovf;

  assign w_hs      = s_valid && r_s_ready && (r_state == ACCUM);
  assign w_sum_nxt = r_sum + SUM_W'(s_data);
  assign w_cnt_nxt = r_cnt + CNT_W'(1);
  assign w_close   = w_hs &&
                     ((w_cnt_nxt == CNT_W'(NO_OF_STEPS)) || s_last);
  assign w_ovf     = {{(32-SUM_W){1'b0}}, r_sum} > 32'(MAX_DEC);

  // converter loads the post-beat sum on the closing handshake
  bin2bcd_seq #(
    .IN_W     (SUM_W),
    .N_DIGITS (N_DIGITS)
  ) u_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (w_close && !w_busy),
    .bin   (w_sum_nxt),
    .busy  (w_busy),
    .done  (w_done),
    .bcd   (w_bcd)
  );

  assign s_ready = r_s_ready;
  assign m_valid = r_m_valid;
  assign m_data  = r_m_data;
  assign m_sum   = r_m_sum;
  assign m_count = r_m_count;
  assign m_ovf   = r_m_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ACCUM;
      r_sum     <= '0;
      r_cnt     <= '0;
      r_s_ready <= 1'b0;
      r_m_valid <= 1'b0;
      r_m_sum   <= '0;
      r_m_count <= '0;
      r_m_ovf   <= 1'b0;
      for (int d = 0; d < N_DIGITS; d++)
        r_m_data[d] <= seg_encode(4'd0, SEG_ACT_LOW);
    end else begin
      unique case (r_state)
        ACCUM: begin
          r_s_ready <= 1'b1;
          if (w_hs) begin
            r_sum <= w_sum_nxt;
            r_cnt <= w_cnt_nxt;
          end
          if (w_close) begin
            r_state   <= CONVERT;
            r_s_ready <= 1'b0;
          end
        end
        CONVERT: begin
          if (w_done) begin
            r_state   <= OUTPUT;
            r_m_valid <= 1'b1;
            r_m_sum   <= r_sum;
            r_m_count <= r_cnt;
            r_m_ovf   <= w_ovf;
            for (int d = 0; d < N_DIGITS; d++)
              r_m_data[d] <= w_ovf
                ? seg_encode(4'd9, SEG_ACT_LOW)
                : seg_encode(w_bcd[4*d +: 4], SEG_ACT_LOW);
          end
        end
        OUTPUT: begin
          if (m_ready) begin
            r_state   <= ACCUM;
            r_m_valid <= 1'b0;
            r_sum     <= '0;
            r_cnt     <= '0;
            r_s_ready <= 1'b1;
          end
        end
        default: r_state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_accum_7seg.sv
// Directed bench: default, WIDTH=8 and active-low
// instances driven from one clock and reset.
module tb_axis_accum_7seg;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       a_valid = 0, a_last = 0, a_mready = 0;
  logic [2:0] a_data = 0;
  logic       a_ready, a_mvalid, a_ovf;
  logic [1:0][6:0] a_mdata;
  logic [5:0] a_sum;
  logic [2:0] a_cnt;

  logic       b_valid = 0, b_last = 0, b_mready = 0;
  logic [7:0] b_data = 0;
  logic       b_ready, b_mvalid, b_ovf;
  logic [1:0][6:0] b_mdata;
  logic [10:0] b_sum;
  logic [2:0] b_cnt;

  logic       c_valid = 0, c_last = 0, c_mready = 0;
  logic [2:0] c_data = 0;
  logic       c_ready, c_mvalid, c_ovf;
  logic [1:0][6:0] c_mdata;
  logic [5:0] c_sum;
  logic [2:0] c_cnt;

  axis_accum_7seg u_a (
    .clk(clk), .rst(rst),
    .s_valid(a_valid), .s_ready(a_ready),
    .s_data(a_data), .s_last(a_last),
    .m_valid(a_mvalid), .m_ready(a_mready),
    .m_data(a_mdata), .m_sum(a_sum),
    .m_count(a_cnt), .m_ovf(a_ovf)
  );

  axis_accum_7seg #(.WIDTH(8)) u_b (
    .clk(clk), .rst(rst),
    .s_valid(b_valid), .s_ready(b_ready),
    .s_data(b_data), .s_last(b_last),
    .m_valid(b_mvalid), .m_ready(b_mready),
    .m_data(b_mdata), .m_sum(b_sum),
    .m_count(b_cnt), .m_ovf(b_ovf)
  );

  axis_accum_7seg #(.SEG_ACT_LOW(1'b1)) u_c (
    .clk(clk), .rst(rst),
    .s_valid(c_valid), .s_ready(c_ready),
    .s_data(c_data), .s_last(c_last),
    .m_valid(c_mvalid), .m_ready(c_mready),
    .m_data(c_mdata), .m_sum(c_sum),
    .m_count(c_cnt), .m_ovf(c_ovf)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag,
                       input longint got,
                       input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  task automatic a_beat(input logic [2:0] d, input logic l);
    int k = 0;
    a_valid = 1'b1; a_data = d; a_last = l;
    while (!a_ready && k < 40) begin @(negedge clk); k++; end
    if (k >= 40) check("a_ready_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic a_wait(output int n);
    n = 0;
    while (!a_mvalid && n < 60) begin @(negedge clk); n++; end
    if (n >= 60) check("a_mvalid_timeout", 0, 1);
  endtask

  task automatic a_take;
    a_valid = 1'b0; a_mready = 1'b1;
    @(negedge clk);
    a_mready = 1'b0;
  endtask

  initial begin
    int n;
    int k;
    repeat (2) @(negedge clk);
    check("rst_mvalid", a_mvalid, 0);
    check("rst_sready", a_ready, 0);
    check("rst_mdata", a_mdata, {7'h3F, 7'h3F});
    check("rst_msum", a_sum, 0);
    check("rst_mcount", a_cnt, 0);
    check("rst_mdata_al", c_mdata, {7'h40, 7'h40});
    rst = 1'b0;

    // T1: full frame 3,7,5,2
    a_beat(3'd3, 1'b0); a_beat(3'd7, 1'b0);
    a_beat(3'd5, 1'b0); a_beat(3'd2, 1'b0);
    a_valid = 1'b0;
    a_wait(n);
    check("t1_latency", n, 6);
    check("t1_sum", a_sum, 17);
    check("t1_mdata", a_mdata, {7'h06, 7'h07});
    check("t1_count", a_cnt, 4);
    check("t1_ovf", a_ovf, 0);
    a_take();
    check("t1_mvalid_drop", a_mvalid, 0);
    check("t1_sready_back", a_ready, 1);

    // T2: 7,7,7,7 with backpressure, s_valid held high
    repeat (4) a_beat(3'd7, 1'b0);
    a_wait(n);
    check("t2_sum", a_sum, 28);
    for (int i = 0; i < 5; i++) begin
      check("t2_hold_mdata", a_mdata, {7'h5B, 7'h7F});
      check("t2_hold_mvalid", a_mvalid, 1);
      check("t2_hold_sready", a_ready, 0);
      @(negedge clk);
    end
    a_take();
    check("t2_mvalid_drop", a_mvalid, 0);

    // T3: early close on s_last
    a_beat(3'd4, 1'b0); a_beat(3'd1, 1'b1);
    a_valid = 1'b0; a_last = 1'b0;
    a_wait(n);
    check("t3_count", a_cnt, 2);
    check("t3_sum", a_sum, 5);
    check("t3_mdata", a_mdata, {7'h3F, 7'h6D});
    a_take();

    // T5: reset during CONVERT drops the frame
    repeat (4) a_beat(3'd5, 1'b0);
    a_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_rst_mvalid", a_mvalid, 0);
    check("t5_rst_sready", a_ready, 0);
    k = 0;
    repeat (10) begin
      @(negedge clk);
      if (a_mvalid) k++;
    end
    check("t5_no_stale", k, 0);
    repeat (4) a_beat(3'd1, 1'b0);
    a_valid = 1'b0;
    a_wait(n);
    check("t5_sum", a_sum, 4);
    check("t5_mdata", a_mdata, {7'h3F, 7'h66});
    a_take();

    // T4: WIDTH=8 overflow
    b_valid = 1'b1; b_data = 8'd255;
    for (int i = 0; i < 4; i++) begin
      k = 0;
      while (!b_ready && k < 40) begin @(negedge clk); k++; end
      if (k >= 40) check("b_ready_timeout", 0, 1);
      @(negedge clk);
    end
    b_valid = 1'b0;
    k = 0;
    while (!b_mvalid && k < 60) begin @(negedge clk); k++; end
    check("t4_latency", k, 11);
    check("t4_sum", b_sum, 1020);
    check("t4_ovf", b_ovf, 1);
    check("t4_mdata", b_mdata, {7'h6F, 7'h6F});
    check("t4_count", b_cnt, 4);
    b_mready = 1'b1; @(negedge clk); b_mready = 1'b0;

    // T6: active-low, single zero beat with s_last
    c_valid = 1'b1; c_data = 3'd0; c_last = 1'b1;
    k = 0;
    while (!c_ready && k < 40) begin @(negedge clk); k++; end
    if (k >= 40) check("c_ready_timeout", 0, 1);
    @(negedge clk);
    c_valid = 1'b0; c_last = 1'b0;
    k = 0;
    while (!c_mvalid && k < 60) begin @(negedge clk); k++; end
    check("t6_mvalid", c_mvalid, 1);
    check("t6_mdata", c_mdata, {7'h40, 7'h40});
    check("t6_count", c_cnt, 1);
    check("t6_sum", c_sum, 0);
    c_mready = 1'b1; @(negedge clk); c_mready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
